cnn_frame_sched: RTL and testbench
==================================

# cnn_frame_sched

Frame scheduler that sits between the pixel source and the simpleCNN core.
- Buffers one 28×28 8-bit image received as a raster pixel stream.
- Pulses the core's START, then feeds it one 5×5 window (200 bits) plus its X/Y coordinates per cycle in raster order.
- Captures the class on the core's DONE and returns it to the consumer through a valid/ready handshake.
- Owns all frame-level sequencing, so the core never sees a partially loaded image.

## Interface
Parameters:
- IMG_W, 28, image width and height in pixels
- KSZ, 5, kernel edge; windows per frame NWIN = (IMG_W−KSZ+1)² = 576
- TIMEOUT, 1024, cycles allowed from last window to core DONE (used only with the timeout feature)

Ports:
- CLK  in  1  clock, all logic on rising edge
- nRST  in  1  asynchronous, active-low reset
- PIX_VALID  in  1  pixel stream valid
- PIX_READY  out  1  scheduler accepts a pixel
- PIX_DATA  in  8  unsigned pixel, raster order, row 0 first
- CNN_START  out  1  one-cycle start pulse to the core
- CNN_X  out  5  window left column 0..23
- CNN_Y  out  5  window top row 0..23
- CNN_IMGIN  out  200  window; pixel (i,j) (row i, col j) at bits [199−8(5i+j) −: 8]
- CNN_DONE  in  1  core completion pulse
- CNN_OUT  in  4  core class, valid with CNN_DONE
- RES_VALID  out  1  result available
- RES_READY  in  1  consumer takes result
- RES_CLASS  out  4  class 0..9 (4'hF = timeout, see Configuration)
- BUSY  out  1  high in every state except LOAD

## Operation
States: LOAD → ISSUE → STREAM → WAIT → RESULT → LOAD.
- LOAD: PIX_READY=1. Each PIX_VALID&PIX_READY beat stores the pixel at the raster index and increments it (0..783). After the beat with index 783, go to ISSUE. No timeout in LOAD.
- ISSUE: one cycle. CNN_START=1, window counter cleared. Go to STREAM.
- STREAM: exactly NWIN cycles. In stream cycle n, drive window n with X=n%24 and Y=n/24. X advances first and wraps 23→0 with Y+1. After n=575, go to WAIT.
- WAIT: CNN_X/CNN_Y/CNN_IMGIN hold window 575. The core may sample one extra window; it must see window 575 again.
  - On CNN_DONE, latch CNN_OUT into RES_CLASS and go to RESULT.
- RESULT: RES_VALID=1 and RES_CLASS held stable until RES_READY is high at an edge. Then return to LOAD with the index at 0.
- CNN_DONE outside WAIT is ignored. PIX_VALID outside LOAD is not accepted.
- IMGIN is formed combinationally from the frame buffer at base (Y, X): pixel(i,j) = buf[(Y+i)·28 + X+j].

## Timing
Reset values:
- PIX_READY=1 (state LOAD), CNN_START=0, CNN_X=0, CNN_Y=0, CNN_IMGIN=0, RES_VALID=0, RES_CLASS=0, BUSY=0.
- Pixel index and window counter are 0. The frame buffer is not cleared.

Cycle behaviour:
- CNN_START is registered and high for exactly one cycle, the ISSUE cycle.
- Stream cycle 0 is the cycle immediately after ISSUE. The core starts consuming at that edge.
- CNN_X, CNN_Y and the window counter are registers. CNN_IMGIN is combinational from them.
- Minimum frame latency, counted from the last pixel beat to RES_VALID: 1 (ISSUE) + 576 (STREAM) + WAIT duration + 1.
- RES_VALID rises the cycle after the CNN_DONE edge.
- A RES_VALID&RES_READY edge returns the block to LOAD on the next cycle, so PIX_READY rises then. There is no overlap between result hand-off and the next load.
- nRST asserted in any state, including mid-STREAM or mid-LOAD, immediately forces the reset values.
  - The partial frame is discarded and the core is not notified.
  - The core shares nRST.

Arithmetic:
- Window counter is 10 bits, compared against NWIN−1.
- Pixel index is 10 bits, compared against IMG_W²−1.
- Address computation uses at least 10-bit unsigned arithmetic.

## Configuration
- CNN_SCHED_TIMEOUT_EN defined:
  - A 11-bit watchdog counts WAIT cycles.
  - If it reaches TIMEOUT with no CNN_DONE, go to RESULT with RES_CLASS=4'hF.
  - A later CNN_DONE is ignored.
- CNN_SCHED_TIMEOUT_EN undefined: WAIT lasts indefinitely until CNN_DONE, and no watchdog logic is synthesized.

## Structure
- Shared package cnn_pkg holds:
  - IMG_W, KSZ, OUT_W=24, NWIN=576, PIX_W=8, WIN_W=200
  - the state encoding (LOAD, ISSUE, STREAM, WAIT, RESULT)
  - CLASS_TIMEOUT=4'hF
- Sub-module cnn_win_mux: combinational 5×5 window extraction from the flat frame buffer given X/Y, including the IMGIN bit packing. It is reused by the bench model.

## Test plan
- Frame of pixel(r,c) = (28r+c) mod 256 → window 0 IMGIN[199:192]=8'h00 and IMGIN[7:0]=8'h74 (116). At X=3,Y=2 (n=51), IMGIN[199:192]=59.
- Stub core raising DONE with OUT=7 three cycles after the last window → RES_VALID high with RES_CLASS=7. Exactly 576 STREAM cycles, and X=23,Y=23 in the last one.
- RES_READY held low for 10 cycles → RES_VALID and RES_CLASS stay stable, and PIX_READY stays 0. One cycle after RES_READY, PIX_READY=1.
- nRST pulse at stream cycle 300 → all outputs return to reset values. A new 784-pixel frame followed by DONE with OUT=2 → RES_CLASS=2.
- PIX_VALID toggled every other cycle → exactly 784 beats accepted, ISSUE follows the 784th beat, and CNN_START is high for one cycle.
- With CNN_SCHED_TIMEOUT_EN and no DONE → RES_CLASS=4'hF after 1024 WAIT cycles. A DONE arriving 5 cycles after that changes nothing.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared geometry, state encoding and class constants for the CNN frame scheduler.
package cnn_pkg;
  localparam int IMG_W = 28;
  localparam int KSZ   = 5;
  localparam int OUT_W = IMG_W - KSZ + 1;
  localparam int NWIN  = OUT_W * OUT_W;
  localparam int PIX_W = 8;
  localparam int WIN_W = KSZ * KSZ * PIX_W;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int FB_W  = NPIX * PIX_W;
  localparam logic [3:0] CLASS_TIMEOUT = 4'hF;
  typedef enum logic [2:0] {LOAD, ISSUE, STREAM, WAIT, RESULT} state_t;
endpackage

// File: rtl/cnn_win_mux.sv
// cnn_win_mux: combinational 5x5 window extraction from the flat frame buffer.
// Pixel (i,j) of the window lands at bits [WIN_W-1-8(5i+j) -: 8].
module cnn_win_mux
  import cnn_pkg::*;
(
  input  logic [FB_W-1:0]  frame_i,
  input  logic [4:0]       x_i,
  input  logic [4:0]       y_i,
  output logic [WIN_W-1:0] win_o
);
  for (genvar i = 0; i < KSZ; i++) begin : g_row
    for (genvar j = 0; j < KSZ; j++) begin : g_col
      logic [9:0] addr;
      assign addr = (10'(y_i) + 10'(i)) * 10'(IMG_W) + 10'(x_i) + 10'(j);
      assign win_o[WIN_W-1-PIX_W*(KSZ*i+j) -: PIX_W] = frame_i[{addr, 3'b000} +: PIX_W];
    end
  end
endmodule

// File: rtl/cnn_frame_sched.sv
// cnn_frame_sched: buffers a 28x28 frame, streams 5x5 windows to the CNN core, returns its class.
// Optional watchdog on the core's DONE is enabled by defining CNN_SCHED_TIMEOUT_EN.
module cnn_frame_sched #(
  parameter int IMG_W   = cnn_pkg::IMG_W,
  parameter int KSZ     = cnn_pkg::KSZ,
  parameter int TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         PIX_VALID,
  output logic         PIX_READY,
  input  logic [7:0]   PIX_DATA,
  output logic         CNN_START,
  output logic [4:0]   CNN_X,
  output logic [4:0]   CNN_Y,
  output logic [199:0] CNN_IMGIN,
  input  logic         CNN_DONE,
  input  logic [3:0]   CNN_OUT,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic [3:0]   RES_CLASS,
  output logic         BUSY
);
  import cnn_pkg::*;
  localparam int OW = IMG_W - KSZ + 1;
  localparam int NW = OW * OW;
  state_t            state_q;
  logic [FB_W-1:0]   fb_q;
  logic [9:0]        pix_idx_q;
  logic [9:0]        win_q;
  logic [4:0]        x_q;
  logic [4:0]        y_q;
  logic              start_q;
  logic [3:0]        class_q;
  logic [WIN_W-1:0]  win;
  logic              beat;
`ifdef CNN_SCHED_TIMEOUT_EN
  logic [10:0]       wd_q;
`endif
  assign beat = PIX_VALID && state_q == LOAD;
  // Frame storage is deliberately not reset; a fresh frame always overwrites it.
  always_ff @(posedge CLK) begin
    if (beat) fb_q[{pix_idx_q, 3'b000} +: PIX_W] <= PIX_DATA;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= LOAD;
      pix_idx_q <= '0;
      win_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      start_q   <= 1'b0;
      class_q   <= '0;
`ifdef CNN_SCHED_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        LOAD: if (PIX_VALID) begin
          pix_idx_q <= pix_idx_q + 10'd1;
          if (pix_idx_q == 10'(IMG_W * IMG_W - 1)) begin
            state_q <= ISSUE;
            start_q <= 1'b1;
          end
        end
        ISSUE: begin
          win_q   <= '0;
          x_q     <= '0;
          y_q     <= '0;
`ifdef CNN_SCHED_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= STREAM;
        end
        STREAM: if (win_q == 10'(NW - 1)) state_q <= WAIT;
        else begin
          win_q <= win_q + 10'd1;
          x_q   <= (x_q == 5'(OW - 1)) ? 5'd0 : x_q + 5'd1;
          y_q   <= (x_q == 5'(OW - 1)) ? y_q + 5'd1 : y_q;
        end
        WAIT: if (CNN_DONE) begin
          class_q <= CNN_OUT;
          state_q <= RESULT;
        end
`ifdef CNN_SCHED_TIMEOUT_EN
        else if (wd_q == 11'(TIMEOUT - 1)) begin
          class_q <= CLASS_TIMEOUT;
          state_q <= RESULT;
        end else wd_q <= wd_q + 11'd1;
`endif
        RESULT: if (RES_READY) begin
          state_q   <= LOAD;
          pix_idx_q <= '0;
        end
        default: state_q <= LOAD;
      endcase
    end
  end
  cnn_win_mux u_win (
    .frame_i (fb_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .win_o   (win)
  );
  assign PIX_READY = state_q == LOAD;
  assign BUSY      = !PIX_READY;
  assign RES_VALID = state_q == RESULT;
  assign RES_CLASS = class_q;
  assign CNN_START = start_q;
  assign CNN_X     = x_q;
  assign CNN_Y     = y_q;
  assign CNN_IMGIN = PIX_READY ? '0 : win;
endmodule

// File: tb/tb_cnn_frame_sched.sv
// tb_cnn_frame_sched: directed checks of load, window streaming, result hand-off and reset.
module tb_cnn_frame_sched;
  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         PIX_VALID = 1'b0;
  logic         PIX_READY;
  logic [7:0]   PIX_DATA = '0;
  logic         CNN_START;
  logic [4:0]   CNN_X;
  logic [4:0]   CNN_Y;
  logic [199:0] CNN_IMGIN;
  logic         CNN_DONE = 1'b0;
  logic [3:0]   CNN_OUT = '0;
  logic         RES_VALID;
  logic         RES_READY = 1'b0;
  logic [3:0]   RES_CLASS;
  logic         BUSY;
  int checks = 0;
  int errors = 0;

  cnn_frame_sched dut (
    .CLK(CLK), .nRST(nRST), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_DATA(PIX_DATA),
    .CNN_START(CNN_START), .CNN_X(CNN_X), .CNN_Y(CNN_Y), .CNN_IMGIN(CNN_IMGIN),
    .CNN_DONE(CNN_DONE), .CNN_OUT(CNN_OUT), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_CLASS(RES_CLASS), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic load_pixels(input int n, input int off, input bit gap, output int beats);
    beats = 0;
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        PIX_VALID = 1'b0;
        PIX_DATA  = 8'h55;
        tick();
      end
      PIX_VALID = 1'b1;
      PIX_DATA  = 8'((k + off) % 256);
      if (PIX_READY) beats++;
      tick();
    end
    PIX_VALID = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({PIX_READY, CNN_START, CNN_X, CNN_Y, RES_VALID, RES_CLASS, BUSY} !== {1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s ctrl got rdy=%0b st=%0b x=%0d y=%0d rv=%0b rc=%0h busy=%0b exp 1 0 0 0 0 0 0",
               tag, PIX_READY, CNN_START, CNN_X, CNN_Y, RES_VALID, RES_CLASS, BUSY);
    end
    checks++;
    if (CNN_IMGIN !== 200'd0) begin
      errors++;
      $display("FAIL %s imgin got %h exp 0", tag, CNN_IMGIN);
    end
  endtask

  // Walks from the ISSUE cycle through all 576 stream cycles; ends in WAIT cycle 0.
  task automatic run_stream;
    int r, c;
    tick();
    for (int n = 0; n < 576; n++) begin
      r = n / 24;
      c = n % 24;
      checks++;
      if ({CNN_X, CNN_Y, CNN_IMGIN[199:192], CNN_IMGIN[111:104], CNN_IMGIN[7:0], CNN_START, BUSY} !==
          {5'(c), 5'(r), 8'((28 * r + c) % 256), 8'((28 * (r + 2) + c + 1) % 256), 8'((28 * (r + 4) + c + 4) % 256), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL stream n=%0d got x=%0d y=%0d p00=%0d p21=%0d p44=%0d st=%0b busy=%0b exp x=%0d y=%0d p00=%0d p21=%0d p44=%0d st=0 busy=1",
                 n, CNN_X, CNN_Y, CNN_IMGIN[199:192], CNN_IMGIN[111:104], CNN_IMGIN[7:0], CNN_START, BUSY,
                 c, r, (28 * r + c) % 256, (28 * (r + 2) + c + 1) % 256, (28 * (r + 4) + c + 4) % 256);
      end
      if (n == 0) begin
        checks++;
        if ({CNN_IMGIN[199:192], CNN_IMGIN[7:0]} !== {8'h00, 8'h74}) begin
          errors++;
          $display("FAIL win0 got p00=%h p44=%h exp 00 74", CNN_IMGIN[199:192], CNN_IMGIN[7:0]);
        end
      end
      if (n == 51) begin
        checks++;
        if ({CNN_X, CNN_Y, CNN_IMGIN[199:192]} !== {5'd3, 5'd2, 8'd59}) begin
          errors++;
          $display("FAIL win51 got x=%0d y=%0d p00=%0d exp 3 2 59", CNN_X, CNN_Y, CNN_IMGIN[199:192]);
        end
      end
      if (n == 100) begin
        CNN_DONE = 1'b1;
        CNN_OUT  = 4'd5;
      end
      tick();
      CNN_DONE = 1'b0;
      CNN_OUT  = 4'd0;
    end
    checks++;
    if ({CNN_X, CNN_Y, CNN_IMGIN[199:192], RES_VALID, CNN_START} !== {5'd23, 5'd23, 8'd155, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wait_hold got x=%0d y=%0d p00=%0d rv=%0b st=%0b exp 23 23 155 0 0",
               CNN_X, CNN_Y, CNN_IMGIN[199:192], RES_VALID, CNN_START);
    end
  endtask

  task automatic check_issue(input string tag);
    checks++;
    if ({CNN_START, PIX_READY, BUSY} !== 3'b101) begin
      errors++;
      $display("FAIL %s issue got st=%0b rdy=%0b busy=%0b exp 1 0 1", tag, CNN_START, PIX_READY, BUSY);
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] cls);
    checks++;
    if ({RES_VALID, RES_CLASS, PIX_READY} !== {1'b1, cls, 1'b0}) begin
      errors++;
      $display("FAIL %s got rv=%0b cls=%0h rdy=%0b exp 1 %0h 0", tag, RES_VALID, RES_CLASS, PIX_READY, cls);
    end
  endtask

  task automatic release_result;
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    nRST = 1'b1;
    tick();
    check_reset_outputs("reset_release");
  endtask

  task automatic test_frame_class7;
    int beats;
    load_pixels(784, 0, 1'b0, beats);
    check_issue("frame1");
    run_stream();
    tick();
    tick();
    checks++;
    if (RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL wait_no_result got rv=%0b exp 0", RES_VALID);
    end
    CNN_DONE = 1'b1;
    CNN_OUT  = 4'd7;
    tick();
    CNN_DONE = 1'b0;
    CNN_OUT  = 4'd0;
    check_result("result7", 4'd7);
  endtask

  task automatic test_result_hold;
    RES_READY = 1'b0;
    PIX_VALID = 1'b1;
    PIX_DATA  = 8'hEE;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_result("hold", 4'd7);
    end
    PIX_VALID = 1'b0;
    release_result();
    checks++;
    if ({PIX_READY, RES_VALID, BUSY} !== 3'b100) begin
      errors++;
      $display("FAIL handoff got rdy=%0b rv=%0b busy=%0b exp 1 0 0", PIX_READY, RES_VALID, BUSY);
    end
  endtask

  task automatic test_reset_mid_stream;
    int beats;
    load_pixels(784, 0, 1'b0, beats);
    for (int k = 0; k <= 300; k++) tick();
    checks++;
    if ({CNN_X, CNN_Y} !== {5'd12, 5'd12}) begin
      errors++;
      $display("FAIL stream300 got x=%0d y=%0d exp 12 12", CNN_X, CNN_Y);
    end
    nRST = 1'b0;
    #1;
    check_reset_outputs("mid_stream_reset");
    tick();
    nRST = 1'b1;
    tick();
    load_pixels(50, 170, 1'b0, beats);
    nRST = 1'b0;
    #1;
    check_reset_outputs("mid_load_reset");
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    int beats;
    load_pixels(784, 0, 1'b1, beats);
    checks++;
    if (beats !== 784) begin
      errors++;
      $display("FAIL beats got %0d exp 784", beats);
    end
    check_issue("toggled");
    run_stream();
    CNN_DONE = 1'b1;
    CNN_OUT  = 4'd2;
    tick();
    CNN_DONE = 1'b0;
    CNN_OUT  = 4'd0;
    check_result("result2", 4'd2);
    release_result();
  endtask

  task automatic test_wait_limit;
    int beats;
    load_pixels(784, 0, 1'b0, beats);
    check_issue("frame4");
    run_stream();
`ifdef CNN_SCHED_TIMEOUT_EN
    for (int k = 0; k < 1023; k++) tick();
    checks++;
    if (RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got rv=%0b exp 0", RES_VALID);
    end
    tick();
    check_result("timeout", 4'hF);
    for (int k = 0; k < 4; k++) tick();
    CNN_DONE = 1'b1;
    CNN_OUT  = 4'd3;
    tick();
    CNN_DONE = 1'b0;
    CNN_OUT  = 4'd0;
    check_result("late_done", 4'hF);
`else
    for (int k = 0; k < 1100; k++) tick();
    checks++;
    if ({RES_VALID, CNN_X, CNN_Y} !== {1'b0, 5'd23, 5'd23}) begin
      errors++;
      $display("FAIL long_wait got rv=%0b x=%0d y=%0d exp 0 23 23", RES_VALID, CNN_X, CNN_Y);
    end
    CNN_DONE = 1'b1;
    CNN_OUT  = 4'd9;
    tick();
    CNN_DONE = 1'b0;
    CNN_OUT  = 4'd0;
    check_result("result9", 4'd9);
`endif
    release_result();
    checks++;
    if (PIX_READY !== 1'b1) begin
      errors++;
      $display("FAIL final_load got rdy=%0b exp 1", PIX_READY);
    end
  endtask

  initial begin
    test_reset();
    test_frame_class7();
    test_result_hold();
    test_reset_mid_stream();
    test_back_to_back();
    test_wait_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
